// File: rtl/mem_pkg.sv
// Shared size encodings, FSM state type and alignment rule for the data-memory access unit.
// Pure declarations; no timing or flow control of its own.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_WR,
    ST_RESP
  } mau_state_t;

  // A request that must be answered with an error instead of a memory access.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = |offset;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering: load extract + sign/zero extend, and store merge into an existing word.
// Purely combinational, no flow control.
module mau_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [31:0] w_rd_shift;
  logic [31:0] w_wr_shift;
  logic [3:0]  w_be;

  assign w_rd_shift = i_word >> {i_offset, 3'b000};
  assign w_wr_shift = i_wdata << {i_offset, 3'b000};

  always_comb begin
    o_load = i_word;
    w_be   = 4'b1111;
    case (i_size)
      SIZE_BYTE: begin
        o_load = {{24{i_signed & w_rd_shift[7]}}, w_rd_shift[7:0]};
        w_be   = 4'b0001 << i_offset;
      end
      SIZE_HALF: begin
        o_load = {{16{i_signed & w_rd_shift[15]}}, w_rd_shift[15:0]};
        w_be   = 4'b0011 << i_offset;
      end
      default: ;
    endcase
  end

  // Lanes not being stored are rewritten with what memory already holds.
  always_comb begin
    o_merged = i_word;
    for (int k = 0; k < 4; k++) begin
      if (w_be[k]) o_merged[8*k +: 8] = w_wr_shift[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide data memory: one request at a time, sub-word stores by read-modify-write.
// Load/word store respond 2 cycles after accept, sub-word store 3, errors 1; response held until resp_ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  mau_state_t        r_state;
  mau_state_t        w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_word;
  logic              r_err;

  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;
  logic              w_bad;

  assign w_bad = req_bad(req_size, req_addr[1:0]);

  mau_lane_align u_align (
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .i_signed (r_signed),
    .i_word   (mem_read_data),
    .i_wdata  (r_word),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // r_word carries store data in, then the merged word or extended load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_word   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_word   <= req_wdata;
            r_err    <= w_bad;
          end
        end
        ST_RD:     r_word <= w_load;
        ST_RMW_RD: r_word <= w_merged;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_bad)                   w_next = ST_RESP;
          else if (!req_we)            w_next = ST_RD;
          else if (req_size == SIZE_WORD) w_next = ST_WR;
          else                         w_next = ST_RMW_RD;
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        w_next   = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_read = 1'b1;
        w_next   = ST_WR;
      end
      ST_WR: begin
        mem_write = 1'b1;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign mem_addr       = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_write_data = mem_write ? r_word : '0;
  assign resp_rdata     = (resp_valid && !r_we && !r_err) ? r_word : '0;
  assign resp_err       = resp_valid & r_err;

endmodule
